regfile_multiport: RTL and testbench

Parametrised integer register file for the single-cycle RISC-V datapath, the successor to the fixed 2-read/1-write, 64-bit, 32-entry file. Width, depth and read-port count are configurable. It adds a hardwired-zero register, write-to-read bypass, and a sequential clear engine that zeroes every entry after reset or on request. It sits between instruction decode (register addresses) and the ALU/writeback mux.

---
 rtl/regfile_multiport.sv | 90 +++++++++
 tb/tb_regfile_multiport.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Parametrised multi-port integer register file with hardwired zero register,
// write-to-read bypass and a sequential clear engine run after reset or on request.
module regfile_multiport #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs,
  output logic [NREAD*XLEN-1:0] ReadData,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       WriteData,
  input  logic                  RegWrite,
  input  logic                  clear_req,
  output logic                  ready
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
  localparam logic [AW:0]   LIMIT = (AW+1)'(NREGS);

  state_t          state, state_next;
  logic [AW-1:0]   count, count_next;
  logic            write_ok;
  logic [XLEN-1:0] regs [NREGS];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // INIT walks the counter over every entry once; a clear request in RUN restarts it
  always_comb begin
    state_next = state;
    count_next = count;
    if (state == INIT) begin
      if (count == LAST) begin
        state_next = RUN;
        count_next = '0;
      end else begin
        count_next = count + 1'b1;
      end
    end else if (clear_req) begin
      state_next = INIT;
      count_next = '0;
    end
  end

  // a clear request takes precedence over a write in the same cycle
  assign write_ok = RegWrite && (state == RUN) && !clear_req && in_range(rd) &&
                    !((ZERO_REG != 0) && (rd == '0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT)
        regs[count] <= '0;
      else if (write_ok)
        regs[rd] <= WriteData;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0] addr;
    logic          masked;
    logic          hit;

    assign addr   = rs[p*AW +: AW];
    assign masked = reset || (state != RUN) || !in_range(addr) ||
                    ((ZERO_REG != 0) && (addr == '0));
    assign hit    = (BYPASS != 0) && write_ok && (rd == addr);
    assign ReadData[p*XLEN +: XLEN] = masked ? '0 : (hit ? WriteData : regs[addr]);
  end

  assign ready = (state == RUN);

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: two 64-bit/32-entry variants sharing stimulus
// (bypass+zero-reg and neither) plus a 32-bit/24-entry/3-port variant.
module tb_regfile_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, reg_write, clear_req;
  logic [9:0]   rs;
  logic [4:0]   rd;
  logic [63:0]  wdata;
  logic [127:0] rd_a, rd_b;
  logic         ready_a, ready_b;

  logic         c_reset, c_reg_write, c_clear;
  logic [14:0]  c_rs;
  logic [4:0]   c_rd;
  logic [31:0]  c_wdata;
  logic [95:0]  c_rdata;
  logic         c_ready;

  regfile_multiport #(.XLEN(64), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rs(rs), .ReadData(rd_a), .rd(rd), .WriteData(wdata),
    .RegWrite(reg_write), .clear_req(clear_req), .ready(ready_a));

  regfile_multiport #(.XLEN(64), .NREGS(32), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rs(rs), .ReadData(rd_b), .rd(rd), .WriteData(wdata),
    .RegWrite(reg_write), .clear_req(clear_req), .ready(ready_b));

  regfile_multiport #(.XLEN(32), .NREGS(24), .NREAD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .reset(c_reset), .rs(c_rs), .ReadData(c_rdata), .rd(c_rd), .WriteData(c_wdata),
    .RegWrite(c_reg_write), .clear_req(c_clear), .ready(c_ready));

  typedef struct {
    string       name;
    logic        wr;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [63:0] a0;
    logic [63:0] a1;
    logic [63:0] b0;
    logic [63:0] b1;
  } vec_t;

  typedef struct {
    string       name;
    int          id;
    logic [63:0] exp;
  } exp_t;

  localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0005;

  vec_t vecs[8];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] actual(input int id);
    case (id)
      0: return rd_a[63:0];
      1: return rd_a[127:64];
      2: return rd_b[63:0];
      3: return rd_b[127:64];
      4: return {63'b0, ready_a};
      5: return {63'b0, ready_b};
      6: return {32'b0, c_rdata[31:0]};
      7: return {32'b0, c_rdata[63:32]};
      8: return {32'b0, c_rdata[95:64]};
      9: return {63'b0, c_ready};
      default: return '0;
    endcase
  endfunction

  task automatic push_exp(input int id, input logic [63:0] v, input string name);
    exp_t e;
    e.name = name;
    e.id   = id;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (actual(e.id) !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, actual(e.id), e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reg_write = v.wr;
    rd        = v.rd;
    wdata     = v.wd;
    rs        = {v.rs1, v.rs0};
    clear_req = 1'b0;
    push_exp(0, v.a0, {v.name, " A.p0"});
    push_exp(1, v.a1, {v.name, " A.p1"});
    push_exp(2, v.b0, {v.name, " B.p0"});
    push_exp(3, v.b1, {v.name, " B.p1"});
  endtask

  // ready must stay low for n-1 edges and rise exactly at edge n
  task automatic ready_ab(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      push_exp(4, {63'b0, k == n}, $sformatf("%s A.ready edge %0d", tag, k));
      push_exp(5, {63'b0, k == n}, $sformatf("%s B.ready edge %0d", tag, k));
      checkOutput();
      clear_req = 1'b0;
    end
  endtask

  task automatic ready_c(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      push_exp(9, {63'b0, k == n}, $sformatf("%s C.ready edge %0d", tag, k));
      checkOutput();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"wr5", 1'b1, 5'd5, D, 5'd5, 5'd5, D, D, 64'h0, 64'h0};
    vecs[1] = '{"rd5", 1'b0, 5'd0, 64'h0, 5'd5, 5'd5, D, D, D, D};
    vecs[2] = '{"wr7", 1'b1, 5'd7, 64'h1234, 5'd7, 5'd5, 64'h1234, D, 64'h0, D};
    vecs[3] = '{"rd7", 1'b0, 5'd0, 64'h0, 5'd7, 5'd7, 64'h1234, 64'h1234, 64'h1234, 64'h1234};
    vecs[4] = '{"wr0", 1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd7, 64'h0, 64'h1234, 64'h0, 64'h1234};
    vecs[5] = '{"rd0", 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 64'hFFFF, 64'hFFFF};
    vecs[6] = '{"wr3", 1'b1, 5'd3, 64'hAA, 5'd3, 5'd4, 64'hAA, 64'h0, 64'h0, 64'h0};
    vecs[7] = '{"rd3", 1'b0, 5'd0, 64'h0, 5'd3, 5'd0, 64'hAA, 64'h0, 64'hAA, 64'hFFFF};

    reset = 1'b1; reg_write = 1'b0; clear_req = 1'b0; rs = '0; rd = '0; wdata = '0;
    c_reset = 1'b1; c_reg_write = 1'b0; c_clear = 1'b0; c_rs = '0; c_rd = '0; c_wdata = '0;

    // outputs held at zero while reset is high, even though storage is uninitialised
    @(negedge clk);
    rs   = {5'd0, 5'd5};
    c_rs = {5'd23, 5'd23, 5'd23};
    #1;
    for (int id = 0; id < 4; id++) push_exp(id, 64'h0, $sformatf("reset read id%0d", id));
    push_exp(4, 64'h0, "reset A.ready");
    push_exp(5, 64'h0, "reset B.ready");
    push_exp(6, 64'h0, "reset C.p0");
    push_exp(9, 64'h0, "reset C.ready");
    checkOutput();

    @(negedge clk);
    reset = 1'b0;
    ready_ab(32, "init");

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs = {5'(31 - i), 5'(i)};
      #1;
      for (int id = 0; id < 4; id++) push_exp(id, 64'h0, $sformatf("cleared reg %0d id%0d", i, id));
      checkOutput();
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput();
    end

    // clear request colliding with a write: the write must be dropped
    @(negedge clk);
    reg_write = 1'b1; rd = 5'd4; wdata = 64'hBB; clear_req = 1'b1; rs = {5'd3, 5'd4};
    #1;
    push_exp(0, 64'h0, "collide A.p0");
    push_exp(1, 64'hAA, "collide A.p1");
    push_exp(2, 64'h0, "collide B.p0");
    push_exp(3, 64'hAA, "collide B.p1");
    push_exp(4, 64'h1, "collide A.ready");
    push_exp(5, 64'h1, "collide B.ready");
    checkOutput();

    @(negedge clk);
    reg_write = 1'b0;
    #1;
    push_exp(4, 64'h0, "clear A.ready drop");
    push_exp(5, 64'h0, "clear B.ready drop");
    push_exp(1, 64'h0, "clearing A.p1");
    push_exp(3, 64'h0, "clearing B.p1");
    checkOutput();
    clear_req = 1'b1;
    ready_ab(32, "clear");

    @(negedge clk);
    rs = {5'd3, 5'd4};
    #1;
    for (int id = 0; id < 4; id++) push_exp(id, 64'h0, $sformatf("post-clear r4/r3 id%0d", id));
    checkOutput();
    @(negedge clk);
    rs = {5'd0, 5'd5};
    #1;
    for (int id = 0; id < 4; id++) push_exp(id, 64'h0, $sformatf("post-clear r5/r0 id%0d", id));
    checkOutput();

    // 24-entry variant: reset mid-INIT restarts a full clear
    @(negedge clk);
    c_reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      push_exp(9, 64'h0, $sformatf("C partial init edge %0d", k));
      checkOutput();
    end
    c_reset = 1'b1;
    #1;
    push_exp(9, 64'h0, "C reset mid-init ready");
    push_exp(6, 64'h0, "C reset mid-init p0");
    checkOutput();
    @(negedge clk);
    c_reset = 1'b0;
    ready_c(24, "C restart");

    @(negedge clk);
    c_reg_write = 1'b1; c_rd = 5'd23; c_wdata = 32'hCAFE_F00D; c_rs = {5'd23, 5'd23, 5'd23};
    #1;
    for (int id = 6; id < 9; id++) push_exp(id, 64'hCAFE_F00D, $sformatf("C wr23 bypass id%0d", id));
    checkOutput();

    @(negedge clk);
    c_reg_write = 1'b0;
    #1;
    for (int id = 6; id < 9; id++) push_exp(id, 64'hCAFE_F00D, $sformatf("C rd23 id%0d", id));
    checkOutput();

    @(negedge clk);
    c_reg_write = 1'b1; c_rd = 5'd30; c_wdata = 32'h55; c_rs = {5'd0, 5'd23, 5'd30};
    #1;
    push_exp(6, 64'h0, "C wr30 p0");
    push_exp(7, 64'hCAFE_F00D, "C wr30 p1");
    push_exp(8, 64'h0, "C wr30 p2");
    checkOutput();

    @(negedge clk);
    c_reg_write = 1'b0; c_rs = {5'd24, 5'd30, 5'd30};
    #1;
    for (int id = 6; id < 9; id++) push_exp(id, 64'h0, $sformatf("C out-of-range id%0d", id));
    checkOutput();

    // asynchronous reset in RUN drops ready before any clock edge
    @(negedge clk);
    c_rs = {5'd23, 5'd23, 5'd23};
    #1;
    push_exp(6, 64'hCAFE_F00D, "C pre-reset p0");
    push_exp(9, 64'h1, "C pre-reset ready");
    checkOutput();
    #2;
    c_reset = 1'b1;
    #1;
    push_exp(9, 64'h0, "C async reset ready");
    push_exp(6, 64'h0, "C async reset p0");
    checkOutput();
    @(negedge clk);
    c_reset = 1'b0;
    ready_c(24, "C rerun");
    @(negedge clk);
    #1;
    push_exp(8, 64'h0, "C re-cleared r23");
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
